alu_result_fifo: RTL and testbench
==================================

Name: alu_result_fifo

Overview:
- Downstream stage of the 3-bit arithmetic unit. It captures each issued operation (A, B, sel) together with the unit's 6-bit result.
- On capture it tags the entry with status flags and buffers it in a small first-word-fallthrough FIFO.
- Results are drained through a valid/ready interface towards the output pins or a host reader.
- The arithmetic unit is combinational and cannot stall, so this block never back-pressures it. Pushes that arrive while the FIFO is full are dropped and recorded in a sticky flag.

Parameters:
- DEPTH, 4, number of entries; power of two, 2..16.
- PTR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous flush of contents and sticky flags.
- in_valid  input  1  an operation result is presented this cycle.
- in_a  input  3  operand A as issued to the arithmetic unit.
- in_b  input  3  operand B as issued to the arithmetic unit.
- in_sel  input  2  op select: 00 add, 01 sub, 10 mul, 11 div.
- in_result  input  6  arithmetic unit result; treated as opaque 6 bits.
- out_valid  output  1  head entry is available.
- out_ready  input  1  consumer accepts the head entry this cycle.
- out_result  output  6  head entry result.
- out_sel  output  2  head entry op select.
- out_zero  output  1  head entry result == 6'd0.
- out_dbz  output  1  head entry was a divide with B == 0.
- count  output  PTR_W+1  number of stored entries, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- drop_sticky  output  1  at least one push was lost since reset or clear.

Behaviour:
- Reset (rst=1, asynchronous): pointers=0, count=0, empty=1, full=0, out_valid=0, drop_sticky=0. out_result, out_sel, out_zero and out_dbz read 0 while empty. Storage contents are don't-care.
- Entry format: {sel[1:0], zero, dbz, result[5:0]}.
  - zero = (in_result == 0).
  - dbz = (in_sel == 2'b11) && (in_b == 3'd0).
  - Both flags are computed combinationally at push time and stored.
- Push: in_valid && (!full || pop). The entry is written at wr_ptr and wr_ptr increments modulo DEPTH.
- Pop: out_valid && out_ready. rd_ptr increments modulo DEPTH.
- out_valid = !empty. The outputs show the entry at rd_ptr combinationally from storage (first-word fallthrough). A pushed entry becomes visible on out_* the cycle after the push edge.
- Latency: push at edge N gives out_valid=1 after edge N when the FIFO was empty. Zero-bubble throughput at one entry per cycle.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
  - full and empty are derived from the registered count.
- Full with simultaneous pop: the push is accepted and count stays DEPTH.
- Full without pop: the push is dropped, drop_sticky is set to 1 on the next edge, and storage and pointers are unchanged.
- Empty with out_ready=1: no pop. With in_valid=1 the push is accepted normally.
- Wrap-around: pointers roll from DEPTH-1 to 0. Ordering is strictly FIFO across the wrap.
- clear=1: on the next edge pointers=0, count=0 and drop_sticky=0. clear overrides any push or pop in the same cycle, and that cycle's input is discarded.
- out_ready when out_valid=0 has no effect.
- Reset asserted mid-stream: all state returns to reset values immediately, without waiting for a clock edge. After deassertion the first accepted push becomes the head.
- No X propagation: outputs are forced to 0 when empty.

Test Plan:
- Reset then idle: rst pulse with no traffic -> out_valid=0, empty=1, count=0, drop_sticky=0, out_result=0.
- Single pass: push a=3, b=2, sel=00, result=6'd5 with out_ready=0 -> the next cycle shows out_valid=1, out_result=5, out_sel=00, out_zero=0, out_dbz=0, count=1. Raise out_ready for one cycle -> empty=1.
- Flags: push sel=11, b=0, result=0, then sel=01, a=2, b=2, result=0 -> first entry out_zero=1, out_dbz=1; second entry out_zero=1, out_dbz=0.
- Overflow:
  - Push results 1,2,3,4 with out_ready=0 -> full=1, count=4.
  - Push 5 -> dropped, drop_sticky=1.
  - Drain -> 1,2,3,4 in order, 5 absent.
- Full with simultaneous push and pop: starting from 4 entries, push 9 with out_ready=1 -> count stays 4, drop_sticky stays 0, and the drain order is 2,3,4,9.
- Wrap and clear:
  - Stream 10 pushes with out_ready=1 every cycle -> every result emerges in order one cycle after its push, and count never exceeds 1.
  - Then fill to 3 entries and assert clear together with in_valid -> count=0 and empty=1 the next cycle, and drop_sticky=0.

Source files
------------

// File: rtl/alu_result_fifo.sv
// Result buffer behind the 3-bit arithmetic unit.
// Tags each issued op with zero/div-by-zero flags and queues it in a FWFT FIFO.
module alu_result_fifo #(
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             in_valid,
   input  logic [2:0]       in_a,
   input  logic [2:0]       in_b,
   input  logic [1:0]       in_sel,
   input  logic [5:0]       in_result,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [5:0]       out_result,
   output logic [1:0]       out_sel,
   output logic             out_zero,
   output logic             out_dbz,
   output logic [PTR_W:0]   count,
   output logic             full,
   output logic             empty,
   output logic             drop_sticky
);

   typedef struct packed {
      logic [1:0] sel;
      logic       zero;
      logic       dbz;
      logic [5:0] result;
   } entry_t;

   localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

   entry_t            mem [DEPTH];
   entry_t            new_entry;
   entry_t            head;
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              push;
   logic              pop;
   logic              drop;
   logic              unused_a;

   // Operand A only matters to the arithmetic unit itself.
   assign unused_a = ^in_a;

   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);

   assign pop  = !empty && out_ready;
   assign push = in_valid && (!full || pop);
   assign drop = in_valid && full && !pop;

   always_comb begin
      new_entry        = '0;
      new_entry.sel    = in_sel;
      new_entry.zero   = (in_result == 6'd0);
      new_entry.dbz    = (in_sel == 2'b11) && (in_b == 3'd0);
      new_entry.result = in_result;
   end

   always_ff @(posedge clk) begin
      if (push && !clear) begin
         mem[wr_ptr] <= new_entry;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         drop_sticky <= 1'b0;
      end else if (clear) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         drop_sticky <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         unique case ({push, pop})
            2'b10:   count <= count + (PTR_W + 1)'(1);
            2'b01:   count <= count - (PTR_W + 1)'(1);
            default: count <= count;
         endcase
         if (drop) begin
            drop_sticky <= 1'b1;
         end
      end
   end

   assign head      = mem[rd_ptr];
   assign out_valid = !empty;

   // Storage is never reset, so mask the head while empty.
   always_comb begin
      out_result = '0;
      out_sel    = '0;
      out_zero   = 1'b0;
      out_dbz    = 1'b0;
      if (!empty) begin
         out_result = head.result;
         out_sel    = head.sel;
         out_zero   = head.zero;
         out_dbz    = head.dbz;
      end
   end

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed bench for alu_result_fifo.
// Hand-computed expectations, sampled 1ns after each rising edge.
module tb_alu_result_fifo;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       clear = 1'b0;
   logic       in_valid = 1'b0;
   logic [2:0] in_a = '0;
   logic [2:0] in_b = '0;
   logic [1:0] in_sel = '0;
   logic [5:0] in_result = '0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [5:0] out_result;
   logic [1:0] out_sel;
   logic       out_zero;
   logic       out_dbz;
   logic [2:0] count;
   logic       full;
   logic       empty;
   logic       drop_sticky;

   int checks = 0;
   int failures = 0;

   alu_result_fifo #(.DEPTH(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .clear       (clear),
      .in_valid    (in_valid),
      .in_a        (in_a),
      .in_b        (in_b),
      .in_sel      (in_sel),
      .in_result   (in_result),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_result  (out_result),
      .out_sel     (out_sel),
      .out_zero    (out_zero),
      .out_dbz     (out_dbz),
      .count       (count),
      .full        (full),
      .empty       (empty),
      .drop_sticky (drop_sticky)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [2:0] a,
                        input logic [2:0] b, input logic [1:0] s,
                        input logic [5:0] r);
      in_valid  = v;
      in_a      = a;
      in_b      = b;
      in_sel    = s;
      in_result = r;
   endtask

   task automatic push_one(input logic [5:0] r);
      drive(1'b1, 3'd1, 3'd1, 2'b00, r);
      tick();
      drive(1'b0, 3'd0, 3'd0, 2'b00, 6'd0);
   endtask

   initial begin
      // reset then idle
      tick();
      tick();
      chk("rst_valid", out_valid, 0);
      chk("rst_empty", empty, 1);
      rst = 1'b0;
      tick();
      chk("idle_valid", out_valid, 0);
      chk("idle_empty", empty, 1);
      chk("idle_full", full, 0);
      chk("idle_count", count, 0);
      chk("idle_drop", drop_sticky, 0);
      chk("idle_result", out_result, 0);

      // single pass
      drive(1'b1, 3'd3, 3'd2, 2'b00, 6'd5);
      tick();
      drive(1'b0, 3'd0, 3'd0, 2'b00, 6'd0);
      chk("sp_valid", out_valid, 1);
      chk("sp_result", out_result, 5);
      chk("sp_sel", out_sel, 0);
      chk("sp_zero", out_zero, 0);
      chk("sp_dbz", out_dbz, 0);
      chk("sp_count", count, 1);
      tick();
      chk("sp_hold", count, 1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("sp_empty", empty, 1);
      chk("sp_masked", out_result, 0);

      // flags
      drive(1'b1, 3'd1, 3'd0, 2'b11, 6'd0);
      tick();
      drive(1'b1, 3'd2, 3'd2, 2'b01, 6'd0);
      tick();
      drive(1'b0, 3'd0, 3'd0, 2'b00, 6'd0);
      chk("fl_count", count, 2);
      chk("fl1_zero", out_zero, 1);
      chk("fl1_dbz", out_dbz, 1);
      chk("fl1_sel", out_sel, 3);
      out_ready = 1'b1;
      tick();
      chk("fl2_zero", out_zero, 1);
      chk("fl2_dbz", out_dbz, 0);
      chk("fl2_sel", out_sel, 1);
      tick();
      out_ready = 1'b0;
      chk("fl_empty", empty, 1);

      // overflow
      for (int i = 1; i <= 4; i++) push_one(6'(i));
      chk("ov_full", full, 1);
      chk("ov_count", count, 4);
      chk("ov_nodrop", drop_sticky, 0);
      push_one(6'd5);
      chk("ov_drop", drop_sticky, 1);
      chk("ov_count2", count, 4);
      out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         chk($sformatf("ov_drain%0d", i), out_result, i);
         tick();
      end
      out_ready = 1'b0;
      chk("ov_empty", empty, 1);
      chk("ov_sticky", drop_sticky, 1);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("clr_drop", drop_sticky, 0);

      // full with simultaneous push and pop
      for (int i = 1; i <= 4; i++) push_one(6'(i));
      out_ready = 1'b1;
      drive(1'b1, 3'd1, 3'd1, 2'b00, 6'd9);
      tick();
      drive(1'b0, 3'd0, 3'd0, 2'b00, 6'd0);
      out_ready = 1'b0;
      chk("fp_count", count, 4);
      chk("fp_drop", drop_sticky, 0);
      out_ready = 1'b1;
      chk("fp_d0", out_result, 2);
      tick();
      chk("fp_d1", out_result, 3);
      tick();
      chk("fp_d2", out_result, 4);
      tick();
      chk("fp_d3", out_result, 9);
      tick();
      chk("fp_empty", empty, 1);

      // streaming across the wrap
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 3'd1, 3'd1, 2'b10, 6'(20 + i));
         tick();
         chk($sformatf("st_res%0d", i), out_result, 20 + i);
         chk($sformatf("st_cnt%0d", i), count, 1);
      end
      drive(1'b0, 3'd0, 3'd0, 2'b00, 6'd0);
      tick();
      out_ready = 1'b0;
      chk("st_empty", empty, 1);

      // fill to 3 then clear with a push
      for (int i = 1; i <= 3; i++) push_one(6'(40 + i));
      chk("cl_count3", count, 3);
      clear = 1'b1;
      drive(1'b1, 3'd1, 3'd1, 2'b00, 6'd7);
      tick();
      clear = 1'b0;
      drive(1'b0, 3'd0, 3'd0, 2'b00, 6'd0);
      chk("cl_count", count, 0);
      chk("cl_empty", empty, 1);
      chk("cl_valid", out_valid, 0);
      chk("cl_drop", drop_sticky, 0);
      push_one(6'd11);
      chk("cl_head", out_result, 11);
      chk("cl_cnt1", count, 1);

      // asynchronous reset mid-stream
      push_one(6'd12);
      chk("ar_pre", count, 2);
      #2;
      rst = 1'b1;
      #1;
      chk("ar_count", count, 0);
      chk("ar_empty", empty, 1);
      chk("ar_valid", out_valid, 0);
      rst = 1'b0;
      tick();
      push_one(6'd13);
      chk("ar_head", out_result, 13);
      chk("ar_cnt1", count, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
